st_symbol_narrowing_adapter: RTL and testbench
==============================================

ST_SYMBOL_NARROWING_ADAPTER -- requirements
Module: st_symbol_narrowing_adapter

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 8, bits per symbol.
REQ-002 SHALL have parameter IN_SYMBOLS, default 3, symbols per input beat (legal 1..16).
REQ-003 SHALL have parameter CHANNEL_WIDTH, default 1, channel field width.
REQ-004 SHALL have parameter ERROR_WIDTH, default 1, error field width.
REQ-005 SHALL have parameter MSB_FIRST, default 1, 1 = emit in_data top symbol first, 0 = bottom symbol first.
REQ-006 SHALL have local EMPTY_WIDTH = max(1, clog2(IN_SYMBOLS)).
REQ-007 clk  input  1  clock, all state on rising edge.
REQ-008 reset_n  input  1  reset, asynchronous, active-low.
REQ-009 in_valid/in_ready  input/output  1/1  Avalon-ST input handshake.
REQ-010 in_data  input  SYMBOL_WIDTH*IN_SYMBOLS  input symbols.
REQ-011 in_startofpacket, in_endofpacket  input  1 each  packet delimiters.
REQ-012 in_empty  input  EMPTY_WIDTH  unused trailing symbols, valid on eop beats only.
REQ-013 in_channel, in_error  input  CHANNEL_WIDTH, ERROR_WIDTH  sideband.
REQ-014 out_valid/out_ready  output/input  1/1  output handshake.
REQ-015 out_data  output  SYMBOL_WIDTH  one symbol per beat.
REQ-016 out_startofpacket, out_endofpacket, out_channel, out_error  output  1,1,CHANNEL_WIDTH,ERROR_WIDTH.

Function
REQ-017 Input stage SHALL register a beat when in_valid && in_ready; in_ready = ~held_valid || (last symbol of held beat transferring this cycle).
REQ-018 Output stage SHALL be registered, loading when out_ready || ~out_valid; first symbol valid on out_* the cycle after the accepting edge.
REQ-019 Symbol index counter SHALL run 0..N-1, N = IN_SYMBOLS on non-eop beats, N = IN_SYMBOLS - in_empty on eop beats.
REQ-020 in_empty >= IN_SYMBOLS on an eop beat SHALL be treated as IN_SYMBOLS-1 (one symbol emitted).
REQ-021 in_empty SHALL be ignored on non-eop beats.
REQ-022 Symbol k SHALL be in_data slice IN_SYMBOLS-1-k when MSB_FIRST=1, slice k when MSB_FIRST=0; empty symbols are the trailing ones in emission order.
REQ-023 out_startofpacket SHALL be set only on symbol 0 of an sop beat; out_endofpacket only on symbol N-1 of an eop beat.
REQ-024 out_channel and out_error SHALL carry the held beat's values on every symbol of that beat.
REQ-025 Counter SHALL advance only on an output load with a valid symbol; wraps to 0 after symbol N-1.
REQ-026 Sustained throughput SHALL be one symbol per clock with back-to-back input beats (no bubble between beats).
REQ-027 out_ready low SHALL freeze out_* and the counter; no symbol lost or duplicated.
REQ-028 IN_SYMBOLS=1 SHALL degenerate to a two-register pass-through with identical handshake.

Reset
REQ-029 Reset SHALL clear in_ready-held state, counter, out_valid, out_startofpacket, out_endofpacket, out_data, out_channel, out_error to 0.
REQ-030 Reset mid-beat SHALL discard the partial beat; first beat after release starts at symbol 0.
REQ-031 in_ready SHALL read 1 combinationally during and after reset (held stage empty).

Structure
REQ-032 Package st_adapter_pkg SHALL hold the clog2 function and EMPTY_WIDTH derivation, shared with future widening adapters.
REQ-033 Symbol selection SHALL be a sub-module st_symbol_select (data, index, MSB_FIRST -> symbol), combinational.

Verification
REQ-034 Default params, 0xAABBCC sop+eop empty 0, out_ready=1 -> AA(sop),BB,CC(eop) on three consecutive cycles.
REQ-035 0xAABBCC sop+eop empty 2 -> single AA with sop and eop; in_ready reasserts next cycle.
REQ-036 Beats 0x112233(sop), 0x445566(eop) back-to-back -> 11..66 on six consecutive cycles, no bubble.
REQ-037 out_ready low for 4 cycles after BB shown -> BB held, then CC; no duplicates.
REQ-038 MSB_FIRST=0, 0xAABBCC empty 1 eop -> CC, BB(eop).
REQ-039 reset_n pulsed low after AA emitted -> outputs 0; next packet 0x010203 emits 01(sop) first.

Source files
------------

// File: rtl/st_adapter_pkg.sv
// rtl/st_adapter_pkg.sv - shared width helpers for Avalon-ST symbol adapters
package st_adapter_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Empty/index fields never shrink below one bit, even for single-symbol beats.
   function automatic int empty_width(input int symbols);
      return (clog2(symbols) > 1) ? clog2(symbols) : 1;
   endfunction

endpackage

// File: rtl/st_symbol_select.sv
// rtl/st_symbol_select.sv - picks the symbol at emission index from a multi-symbol beat
module st_symbol_select
   import st_adapter_pkg::*;
#(
   parameter int SYMBOL_WIDTH = 8,
   parameter int IN_SYMBOLS   = 3,
   parameter int MSB_FIRST    = 1,
   parameter int IDX_WIDTH    = empty_width(IN_SYMBOLS)
) (
   input  logic [SYMBOL_WIDTH*IN_SYMBOLS-1:0] data_i,
   input  logic [IDX_WIDTH-1:0]               index_i,
   output logic [SYMBOL_WIDTH-1:0]            symbol_o
);

   always_comb begin
      symbol_o = '0;
      for (int k = 0; k < IN_SYMBOLS; k++) begin
         if (int'(index_i) == k) begin
            symbol_o = data_i[((MSB_FIRST != 0) ? (IN_SYMBOLS - 1 - k) : k) * SYMBOL_WIDTH +: SYMBOL_WIDTH];
         end
      end
   end

endmodule

// File: rtl/st_symbol_narrowing_adapter.sv
// rtl/st_symbol_narrowing_adapter.sv - splits multi-symbol Avalon-ST beats into one symbol per beat
module st_symbol_narrowing_adapter
   import st_adapter_pkg::*;
#(
   parameter int SYMBOL_WIDTH  = 8,
   parameter int IN_SYMBOLS    = 3,
   parameter int CHANNEL_WIDTH = 1,
   parameter int ERROR_WIDTH   = 1,
   parameter int MSB_FIRST     = 1,
   localparam int EMPTY_WIDTH  = empty_width(IN_SYMBOLS)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [SYMBOL_WIDTH*IN_SYMBOLS-1:0] in_data,
   input  logic                             in_startofpacket,
   input  logic                             in_endofpacket,
   input  logic [EMPTY_WIDTH-1:0]           in_empty,
   input  logic [CHANNEL_WIDTH-1:0]         in_channel,
   input  logic [ERROR_WIDTH-1:0]           in_error,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [SYMBOL_WIDTH-1:0]          out_data,
   output logic                             out_startofpacket,
   output logic                             out_endofpacket,
   output logic [CHANNEL_WIDTH-1:0]         out_channel,
   output logic [ERROR_WIDTH-1:0]           out_error
);

   localparam int DATA_WIDTH = SYMBOL_WIDTH * IN_SYMBOLS;
   localparam int IDX_WIDTH  = EMPTY_WIDTH;
   localparam logic [IDX_WIDTH-1:0] FULL_LAST = IDX_WIDTH'(IN_SYMBOLS - 1);

   logic                     held_valid_q, held_valid_d;
   logic [DATA_WIDTH-1:0]    held_data_q, held_data_d;
   logic                     held_sop_q, held_sop_d;
   logic                     held_eop_q, held_eop_d;
   logic [IDX_WIDTH-1:0]     held_last_q, held_last_d;
   logic [CHANNEL_WIDTH-1:0] held_channel_q, held_channel_d;
   logic [ERROR_WIDTH-1:0]   held_error_q, held_error_d;
   logic [IDX_WIDTH-1:0]     idx_q, idx_d;
   logic                     out_valid_q, out_valid_d;
   logic [SYMBOL_WIDTH-1:0]  out_data_q, out_data_d;
   logic                     out_sop_q, out_sop_d;
   logic                     out_eop_q, out_eop_d;
   logic [CHANNEL_WIDTH-1:0] out_channel_q, out_channel_d;
   logic [ERROR_WIDTH-1:0]   out_error_q, out_error_d;

   logic                     out_load, sym_take, sym_last, accept;
   logic [IDX_WIDTH-1:0]     beat_last;
   logic [SYMBOL_WIDTH-1:0]  cur_symbol;

   st_symbol_select #(
      .SYMBOL_WIDTH (SYMBOL_WIDTH),
      .IN_SYMBOLS   (IN_SYMBOLS),
      .MSB_FIRST    (MSB_FIRST),
      .IDX_WIDTH    (IDX_WIDTH)
   ) u_select (
      .data_i   (held_data_q),
      .index_i  (idx_q),
      .symbol_o (cur_symbol)
   );

   assign out_load = out_ready || !out_valid_q;
   assign sym_take = out_load && held_valid_q;
   assign sym_last = (idx_q == held_last_q);
   // Refill the held beat on the same edge its last symbol leaves, so beats stream without a bubble.
   assign in_ready = !held_valid_q || (sym_take && sym_last);
   assign accept   = in_valid && in_ready;

   // Oversized empty on an eop beat still leaves one symbol to carry the eop.
   always_comb begin
      beat_last = FULL_LAST;
      if (in_endofpacket) begin
         if (int'(in_empty) >= IN_SYMBOLS) beat_last = '0;
         else                              beat_last = IDX_WIDTH'(IN_SYMBOLS - 1 - int'(in_empty));
      end
   end

   always_comb begin
      held_valid_d   = held_valid_q;
      held_data_d    = held_data_q;
      held_sop_d     = held_sop_q;
      held_eop_d     = held_eop_q;
      held_last_d    = held_last_q;
      held_channel_d = held_channel_q;
      held_error_d   = held_error_q;
      idx_d          = idx_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_sop_d      = out_sop_q;
      out_eop_d      = out_eop_q;
      out_channel_d  = out_channel_q;
      out_error_d    = out_error_q;

      if (sym_take && sym_last) held_valid_d = 1'b0;
      if (accept) begin
         held_valid_d   = 1'b1;
         held_data_d    = in_data;
         held_sop_d     = in_startofpacket;
         held_eop_d     = in_endofpacket;
         held_last_d    = beat_last;
         held_channel_d = in_channel;
         held_error_d   = in_error;
      end

      if (sym_take) idx_d = sym_last ? '0 : idx_q + IDX_WIDTH'(1);

      if (out_load) begin
         out_valid_d = held_valid_q;
         if (held_valid_q) begin
            out_data_d    = cur_symbol;
            out_sop_d     = held_sop_q && (idx_q == '0);
            out_eop_d     = held_eop_q && sym_last;
            out_channel_d = held_channel_q;
            out_error_d   = held_error_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held_valid_q   <= 1'b0;
         held_data_q    <= '0;
         held_sop_q     <= 1'b0;
         held_eop_q     <= 1'b0;
         held_last_q    <= '0;
         held_channel_q <= '0;
         held_error_q   <= '0;
         idx_q          <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_sop_q      <= 1'b0;
         out_eop_q      <= 1'b0;
         out_channel_q  <= '0;
         out_error_q    <= '0;
      end else begin
         held_valid_q   <= held_valid_d;
         held_data_q    <= held_data_d;
         held_sop_q     <= held_sop_d;
         held_eop_q     <= held_eop_d;
         held_last_q    <= held_last_d;
         held_channel_q <= held_channel_d;
         held_error_q   <= held_error_d;
         idx_q          <= idx_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_sop_q      <= out_sop_d;
         out_eop_q      <= out_eop_d;
         out_channel_q  <= out_channel_d;
         out_error_q    <= out_error_d;
      end
   end

   assign out_valid         = out_valid_q;
   assign out_data          = out_data_q;
   assign out_startofpacket = out_sop_q;
   assign out_endofpacket   = out_eop_q;
   assign out_channel       = out_channel_q;
   assign out_error         = out_error_q;

endmodule

// File: tb/tb_st_symbol_narrowing_adapter.sv
// tb/tb_st_symbol_narrowing_adapter.sv - self-checking bench for st_symbol_narrowing_adapter
module tb_st_symbol_narrowing_adapter;

   localparam int NS = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, in_valid, in_sop, in_eop, out_ready;
   logic [23:0] in_data;
   logic [1:0]  in_empty;
   logic [0:0]  in_channel, in_error;

   logic       in_ready_m, out_valid_m, out_sop_m, out_eop_m;
   logic [7:0] out_data_m;
   logic [0:0] out_channel_m, out_error_m;
   logic       in_ready_l, out_valid_l, out_sop_l, out_eop_l;
   logic [7:0] out_data_l;
   logic [0:0] out_channel_l, out_error_l;

   st_symbol_narrowing_adapter #(.MSB_FIRST(1)) dut_m (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
      .in_channel(in_channel), .in_error(in_error),
      .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
      .out_startofpacket(out_sop_m), .out_endofpacket(out_eop_m),
      .out_channel(out_channel_m), .out_error(out_error_m)
   );

   st_symbol_narrowing_adapter #(.MSB_FIRST(0)) dut_l (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
      .in_channel(in_channel), .in_error(in_error),
      .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
      .out_startofpacket(out_sop_l), .out_endofpacket(out_eop_l),
      .out_channel(out_channel_l), .out_error(out_error_l)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic       ch;
      logic       err;
   } sym_t;

   typedef struct {
      logic [23:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic        ch;
      logic        err;
      int          n;
      logic [23:0] exp_m;
      logic [23:0] exp_l;
   } vec_t;

   sym_t q_m[$];
   sym_t q_l[$];
   int   out_cycles[$];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endfunction

   function automatic sym_t mk(input logic [7:0] d, input logic s, input logic e, input logic c, input logic r);
      sym_t t;
      t.data = d; t.sop = s; t.eop = e; t.ch = c; t.err = r;
      return t;
   endfunction

   // Reference: slice the beat in emission order, dropping trailing empty symbols on eop beats.
   function automatic void push_model(input logic [23:0] d, input logic s, input logic e,
                                      input logic [1:0] em, input logic c, input logic r);
      int n;
      logic [23:0] sh_m, sh_l;
      n = e ? NS - ((int'(em) >= NS) ? NS - 1 : int'(em)) : NS;
      for (int k = 0; k < n; k++) begin
         sh_m = d >> (8 * (NS - 1 - k));
         sh_l = d >> (8 * k);
         q_m.push_back(mk(sh_m[7:0], s && k == 0, e && k == n - 1, c, r));
         q_l.push_back(mk(sh_l[7:0], s && k == 0, e && k == n - 1, c, r));
      end
   endfunction

   function automatic void push_table(input vec_t v);
      logic [23:0] tm, tl;
      tm = v.exp_m;
      tl = v.exp_l;
      for (int k = 0; k < v.n; k++) begin
         q_m.push_back(mk(tm[23 - 8 * k -: 8], v.sop && k == 0, v.eop && k == v.n - 1, v.ch, v.err));
         q_l.push_back(mk(tl[23 - 8 * k -: 8], v.sop && k == 0, v.eop && k == v.n - 1, v.ch, v.err));
      end
   endfunction

   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid_m && out_ready) begin
            out_cycles.push_back(cyc);
            if (q_m.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL msb_unexpected: got symbol %0h, expected none", out_data_m);
            end else begin
               check("msb_symbol", {out_data_m, out_sop_m, out_eop_m, out_channel_m, out_error_m}, q_m.pop_front());
            end
         end
         if (out_valid_l && out_ready) begin
            if (q_l.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL lsb_unexpected: got symbol %0h, expected none", out_data_l);
            end else begin
               check("lsb_symbol", {out_data_l, out_sop_l, out_eop_l, out_channel_l, out_error_l}, q_l.pop_front());
            end
         end
      end
   end

   // Called and returns at posedge+1; returns right after the accepting edge.
   task automatic send(input logic [23:0] d, input logic s, input logic e,
                       input logic [1:0] em, input logic c, input logic r);
      logic accepted;
      accepted = 1'b0;
      in_data = d; in_sop = s; in_eop = e; in_empty = em; in_channel = c; in_error = r;
      in_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready_m) begin
            @(posedge clk); #1;
            accepted = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!accepted) check("accept_timeout", accepted, 1'b1);
   endtask

   task automatic drain();
      for (int t = 0; t < 200; t++) begin
         if (q_m.size() == 0 && q_l.size() == 0) break;
         @(negedge clk);
      end
      check("drain", q_m.size() + q_l.size(), 0);
      @(posedge clk); #1;
   endtask

   vec_t tbl[7];
   bit   rand_done;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d vectors applied", nvec);
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{24'hAABBCC, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3, 24'hAABBCC, 24'hCCBBAA};
      tbl[1] = '{24'hAABBCC, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1, 24'hAA0000, 24'hCC0000};
      tbl[2] = '{24'hAABBCC, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2, 24'hAABB00, 24'hCCBB00};
      tbl[3] = '{24'h112233, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 3, 24'h112233, 24'h332211};
      tbl[4] = '{24'h445566, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3, 24'h445566, 24'h665544};
      tbl[5] = '{24'hDEADBE, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1, 24'hDE0000, 24'hBE0000};
      tbl[6] = '{24'h0F1E2D, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 3, 24'h0F1E2D, 24'h2D1E0F};

      reset_n = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
      in_empty = '0; in_channel = '0; in_error = '0; out_ready = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      check("reset_outputs_m", {out_valid_m, out_data_m, out_sop_m, out_eop_m, out_channel_m, out_error_m}, 0);
      check("reset_outputs_l", {out_valid_l, out_data_l, out_sop_l, out_eop_l, out_channel_l, out_error_l}, 0);
      check("reset_in_ready", in_ready_m, 1'b1);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_reset", in_ready_m, 1'b1);

      for (int i = 0; i < 7; i++) begin
         out_cycles.delete();
         send(tbl[i].data, tbl[i].sop, tbl[i].eop, tbl[i].empty, tbl[i].ch, tbl[i].err);
         push_table(tbl[i]);
         @(negedge clk);
         check("in_ready_next_cycle", in_ready_m, tbl[i].n == 1);
         @(posedge clk); #1;
         drain();
         check("symbol_count", out_cycles.size(), tbl[i].n);
         if (out_cycles.size() > 0)
            check("consecutive", out_cycles[out_cycles.size() - 1] - out_cycles[0], tbl[i].n - 1);
      end

      out_cycles.delete();
      send(24'h112233, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      push_model(24'h112233, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      send(24'h445566, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      push_model(24'h445566, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
      drain();
      check("b2b_count", out_cycles.size(), 6);
      if (out_cycles.size() > 0)
         check("b2b_no_bubble", out_cycles[out_cycles.size() - 1] - out_cycles[0], 5);

      out_ready = 1'b0;
      send(24'hAABBCC, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
      push_model(24'hAABBCC, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      for (int h = 0; h < 4; h++) begin
         @(negedge clk);
         check("hold_bb_m", {out_valid_m, out_data_m}, {1'b1, 8'hBB});
         check("hold_bb_l", {out_valid_l, out_data_l}, {1'b1, 8'hBB});
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      drain();

      send(24'hAABBCC, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
      push_model(24'hAABBCC, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      reset_n = 1'b0;
      q_m.delete();
      q_l.delete();
      #1;
      check("midreset_outputs_m", {out_valid_m, out_data_m, out_sop_m, out_eop_m, out_channel_m, out_error_m}, 0);
      check("midreset_in_ready", in_ready_m, 1'b1);
      @(posedge clk);
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;
      send(24'h010203, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
      push_model(24'h010203, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
      drain();

      rand_done = 1'b0;
      fork
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
         begin
            for (int b = 0; b < 300; b++) begin
               logic [23:0] d;
               logic s, e, c, r;
               logic [1:0] em;
               d = $urandom; s = $urandom_range(0, 1) == 1; e = $urandom_range(0, 1) == 1;
               em = 2'($urandom_range(0, 3)); c = $urandom_range(0, 1) == 1; r = $urandom_range(0, 1) == 1;
               send(d, s, e, em, c, r);
               push_model(d, s, e, em, c, r);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
            end
            rand_done = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
